// File: rtl/rx_dispatch.sv
// rx_dispatch: decodes one read instruction into held per-buffer config handshakes {i,d,p,a},
// tracks buffer completion and reports it. Define RX_TIMEOUT_EN to enable the WAIT watchdog.
module rx_dispatch #(
    parameter int unsigned PE_NUM      = 32,
    parameter int unsigned GRP_SIZE    = 4,
    parameter int unsigned INST_W      = 64,
    parameter int unsigned TD_RATE     = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        layer_type,
    input  logic [3:0]        in_ch_seg,
    input  logic [3:0]        out_ch_seg,
    input  logic              depool,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [INST_W-1:0] ins,
    output logic [3:0]        conf_valid,
    input  logic [3:0]        conf_ready,
    output logic [3:0]        conf_mode,
    output logic [15:0]       conf_num,
    output logic [3:0]        conf_ch_num,
    output logic [3:0]        conf_row_num,
    output logic [3:0]        conf_pix_num,
    output logic [PE_NUM-1:0] conf_mask,
    output logic              conf_depool,
    input  logic [3:0]        buf_done,
    output logic              rx_done_pulse,
    output logic [PE_NUM-1:0] buf_mask,
    output logic [3:0]        buf_type,
    output logic              err_pulse,
    output logic [1:0]        ddr1_ready_mux,
    output logic [1:0]        ddr2_ready_mux
);

    localparam logic [3:0] RD_OP_D  = 4'h0;
    localparam logic [3:0] RD_OP_DW = 4'h1;
    localparam logic [3:0] RD_OP_G  = 4'h4;

    localparam int unsigned BIT_I   = 3;
    localparam int unsigned BIT_D   = 2;
    localparam int unsigned BIT_P   = 1;
    localparam int unsigned BIT_A   = 0;
    localparam int unsigned GRP_NUM = PE_NUM / GRP_SIZE;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        tgt_q, tgt_d;
    logic [3:0]        conf_valid_q, conf_valid_d;
    logic [3:0]        hs_seen_q, hs_seen_d;
    logic [3:0]        done_q, done_d;
    logic [3:0]        conf_mode_q, conf_mode_d;
    logic [15:0]       conf_num_q, conf_num_d;
    logic [3:0]        conf_ch_q, conf_ch_d;
    logic [3:0]        conf_row_q, conf_row_d;
    logic [3:0]        conf_pix_q, conf_pix_d;
    logic [PE_NUM-1:0] conf_mask_q, conf_mask_d;
    logic              conf_depool_q, conf_depool_d;
    logic [PE_NUM-1:0] buf_mask_q, buf_mask_d;
    logic [3:0]        buf_type_q, buf_type_d;
    logic [1:0]        ddr1_q, ddr1_d;
    logic [1:0]        ddr2_q, ddr2_d;

    // Instruction fields; p_size overlaps row_num/pix_num by design.
    logic [3:0]  opcode;
    logic [5:0]  buf_id;
    logic [11:0] p_size;
    logic [3:0]  row_num;
    logic [3:0]  pix_num;
    logic [7:0]  size;
    logic        unused_ins;

    assign opcode     = ins[61:58];
    assign buf_id     = ins[57:52];
    assign p_size     = ins[51:40];
    assign row_num    = ins[47:44];
    assign pix_num    = ins[43:40];
    assign size       = ins[39:32];
    assign unused_ins = ^{ins[INST_W-1:62], ins[31:0]};

    logic              pe_mode;
    logic [3:0]        dec_tgt;
    logic              dec_legal;
    logic              id_in_range;
    logic [PE_NUM-1:0] sel_mask;
    logic [PE_NUM-1:0] grp_mask;
    logic [PE_NUM-1:0] dec_mask;
    logic [15:0]       dec_num;
    logic [3:0]        dec_ch;
    logic [3:0]        dec_row;
    logic [3:0]        dec_pix;

    assign pe_mode = (layer_type[2:1] == 2'b10);

    always_comb begin
        dec_tgt   = 4'b0000;
        dec_legal = 1'b1;
        case (opcode)
            RD_OP_DW: begin
                dec_tgt[BIT_I] = 1'b1;
                dec_tgt[BIT_P] = !pe_mode;
            end
            RD_OP_D: begin
                dec_tgt[BIT_D] = 1'b1;
            end
            RD_OP_G: begin
                dec_tgt[BIT_D] = 1'b1;
                dec_tgt[BIT_P] = pe_mode;
            end
            default: begin
                dec_tgt[BIT_A] = pe_mode;
                dec_legal      = pe_mode;
            end
        endcase

        for (int k = 0; k < PE_NUM; k++) begin
            sel_mask[k] = (32'(k) == 32'(buf_id));
            grp_mask[k] = ((32'(k) / GRP_SIZE) == 32'(buf_id));
        end
        // An id whose mask would reach past the last PE is rejected rather than truncated.
        id_in_range = layer_type[0] ? (32'(buf_id) < PE_NUM) : (32'(buf_id) < GRP_NUM);

        if (dec_tgt[BIT_D]) begin
            dec_mask = '1;
        end else begin
            dec_mask  = layer_type[0] ? sel_mask : grp_mask;
            dec_legal = dec_legal && id_in_range;
        end
    end

    // Shared payload bus: i owns num over p, p owns ch_num over d.
    always_comb begin
        dec_num = 16'h0000;
        dec_ch  = 4'h0;
        dec_row = 4'h0;
        dec_pix = 4'h0;
        if (dec_tgt[BIT_A]) begin
            dec_num = opcode[1] ? 16'(32'(p_size) * TD_RATE) : {4'h0, p_size};
        end
        if (dec_tgt[BIT_D]) begin
            dec_ch  = in_ch_seg;
            dec_row = row_num;
            dec_pix = pix_num;
        end
        if (dec_tgt[BIT_P]) begin
            dec_num = {4'h0, p_size};
            dec_ch  = (opcode == RD_OP_G) ? out_ch_seg : size[3:0];
        end
        if (dec_tgt[BIT_I]) begin
            dec_num = {8'h00, size};
        end
    end

    logic tmo_hit;

`ifdef RX_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_cnt_d = (state_q == StWait) ? tmo_cnt_q + 16'd1 : 16'd0;
    assign tmo_hit   = (state_q == StWait) && (tmo_cnt_q == 16'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    logic [3:0] handshake;
    logic [3:0] done_hit;

    assign handshake = conf_valid_q & conf_ready;
    // A done only counts once its buffer has been configured in an earlier cycle.
    assign done_hit  = buf_done & tgt_q & hs_seen_q;

    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        conf_valid_d  = conf_valid_q;
        hs_seen_d     = hs_seen_q;
        done_d        = done_q;
        conf_mode_d   = conf_mode_q;
        conf_num_d    = conf_num_q;
        conf_ch_d     = conf_ch_q;
        conf_row_d    = conf_row_q;
        conf_pix_d    = conf_pix_q;
        conf_mask_d   = conf_mask_q;
        conf_depool_d = conf_depool_q;
        buf_mask_d    = buf_mask_q;
        buf_type_d    = buf_type_q;
        ddr1_d        = ddr1_q;
        ddr2_d        = ddr2_q;

        unique case (state_q)
            StIdle: begin
                if (ins_valid) begin
                    if (!dec_legal) begin
                        state_d = StErr;
                    end else begin
                        state_d       = StIssue;
                        tgt_d         = dec_tgt;
                        conf_valid_d  = dec_tgt;
                        hs_seen_d     = 4'b0000;
                        done_d        = 4'b0000;
                        conf_mode_d   = layer_type;
                        conf_num_d    = dec_num;
                        conf_ch_d     = dec_ch;
                        conf_row_d    = dec_row;
                        conf_pix_d    = dec_pix;
                        conf_mask_d   = dec_mask;
                        conf_depool_d = depool;
                        case (dec_tgt)
                            4'b0100: begin ddr1_d = 2'b00; ddr2_d = 2'b00; end
                            4'b1010: begin ddr1_d = 2'b01; ddr2_d = 2'b01; end
                            4'b1000: begin ddr1_d = 2'b01; ddr2_d = 2'b10; end
                            4'b0010: begin ddr1_d = 2'b10; end
                            4'b0001: begin ddr2_d = 2'b10; end
                            4'b0110: begin ddr1_d = 2'b00; ddr2_d = 2'b01; end
                            default: ;
                        endcase
                    end
                end
            end
            StIssue: begin
                conf_valid_d = conf_valid_q & ~handshake;
                hs_seen_d    = hs_seen_q | handshake;
                done_d       = done_q | done_hit;
                if (conf_valid_d == 4'b0000) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                done_d = done_q | done_hit;
                if (done_d == tgt_q) begin
                    state_d    = StDone;
                    buf_mask_d = conf_mask_q;
                    buf_type_d = tgt_q;
                end else if (tmo_hit) begin
                    state_d = StErr;
                    done_d  = 4'b0000;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            tgt_q         <= 4'b0000;
            conf_valid_q  <= 4'b0000;
            hs_seen_q     <= 4'b0000;
            done_q        <= 4'b0000;
            conf_mode_q   <= 4'h0;
            conf_num_q    <= 16'h0000;
            conf_ch_q     <= 4'h0;
            conf_row_q    <= 4'h0;
            conf_pix_q    <= 4'h0;
            conf_mask_q   <= '0;
            conf_depool_q <= 1'b0;
            buf_mask_q    <= '0;
            buf_type_q    <= 4'b0000;
            ddr1_q        <= 2'b00;
            ddr2_q        <= 2'b00;
        end else begin
            state_q       <= state_d;
            tgt_q         <= tgt_d;
            conf_valid_q  <= conf_valid_d;
            hs_seen_q     <= hs_seen_d;
            done_q        <= done_d;
            conf_mode_q   <= conf_mode_d;
            conf_num_q    <= conf_num_d;
            conf_ch_q     <= conf_ch_d;
            conf_row_q    <= conf_row_d;
            conf_pix_q    <= conf_pix_d;
            conf_mask_q   <= conf_mask_d;
            conf_depool_q <= conf_depool_d;
            buf_mask_q    <= buf_mask_d;
            buf_type_q    <= buf_type_d;
            ddr1_q        <= ddr1_d;
            ddr2_q        <= ddr2_d;
        end
    end

    assign ins_ready      = (state_q == StIdle);
    assign rx_done_pulse  = (state_q == StDone);
    assign err_pulse      = (state_q == StErr);
    assign conf_valid     = conf_valid_q;
    assign conf_mode      = conf_mode_q;
    assign conf_num       = conf_num_q;
    assign conf_ch_num    = conf_ch_q;
    assign conf_row_num   = conf_row_q;
    assign conf_pix_num   = conf_pix_q;
    assign conf_mask      = conf_mask_q;
    assign conf_depool    = conf_depool_q;
    assign buf_mask       = buf_mask_q;
    assign buf_type       = buf_type_q;
    assign ddr1_ready_mux = ddr1_q;
    assign ddr2_ready_mux = ddr2_q;

endmodule

// File: tb/tb_rx_dispatch.sv
// tb_rx_dispatch: directed vectors; expected handshakes, completions and errors are queued at
// issue time and matched by a negedge monitor.
module tb_rx_dispatch;

    localparam int PE_NUM = 32;
    localparam int INST_W = 64;

    localparam logic [3:0] OP_D  = 4'h0;
    localparam logic [3:0] OP_DW = 4'h1;
    localparam logic [3:0] OP_G  = 4'h4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        layer_type, in_ch_seg, out_ch_seg;
    logic              depool, ins_valid, ins_ready;
    logic [INST_W-1:0] ins;
    logic [3:0]        conf_valid, conf_ready, conf_mode, conf_ch_num, conf_row_num, conf_pix_num;
    logic [15:0]       conf_num;
    logic [PE_NUM-1:0] conf_mask, buf_mask;
    logic              conf_depool, rx_done_pulse, err_pulse;
    logic [3:0]        buf_done, buf_type;
    logic [1:0]        ddr1_ready_mux, ddr2_ready_mux;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          b;
        logic [15:0] num;
        logic [3:0]  ch, row, pix, mode;
        logic [31:0] mask;
        logic        dp;
    } conf_t;

    typedef struct {
        logic [31:0] mask;
        logic [3:0]  typ;
    } done_t;

    conf_t conf_exp[$];
    done_t done_exp[$];
    int    err_pending = 0;

    rx_dispatch #(
        .PE_NUM     (32),
        .GRP_SIZE   (4),
        .INST_W     (64),
        .TD_RATE    (4),
        .TIMEOUT_CYC(65535)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .layer_type    (layer_type),
        .in_ch_seg     (in_ch_seg),
        .out_ch_seg    (out_ch_seg),
        .depool        (depool),
        .ins_valid     (ins_valid),
        .ins_ready     (ins_ready),
        .ins           (ins),
        .conf_valid    (conf_valid),
        .conf_ready    (conf_ready),
        .conf_mode     (conf_mode),
        .conf_num      (conf_num),
        .conf_ch_num   (conf_ch_num),
        .conf_row_num  (conf_row_num),
        .conf_pix_num  (conf_pix_num),
        .conf_mask     (conf_mask),
        .conf_depool   (conf_depool),
        .buf_done      (buf_done),
        .rx_done_pulse (rx_done_pulse),
        .buf_mask      (buf_mask),
        .buf_type      (buf_type),
        .err_pulse     (err_pulse),
        .ddr1_ready_mux(ddr1_ready_mux),
        .ddr2_ready_mux(ddr2_ready_mux)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [5:0] id,
                                       input logic [11:0] psz, input logic [7:0] sz);
        logic [63:0] w;
        w = '0;
        w[61:58] = op;
        w[57:52] = id;
        w[51:40] = psz;
        w[39:32] = sz;
        return w;
    endfunction

    task automatic push_conf(input logic [3:0] tgt, input logic [15:0] num, input logic [3:0] ch,
                             input logic [3:0] row, input logic [3:0] pix, input logic [3:0] mode,
                             input logic [31:0] mask, input logic dp);
        conf_t e;
        for (int b = 3; b >= 0; b--) begin
            if (tgt[b]) begin
                e.b = b; e.num = num; e.ch = ch; e.row = row; e.pix = pix;
                e.mode = mode; e.mask = mask; e.dp = dp;
                conf_exp.push_back(e);
            end
        end
    endtask

    task automatic push_done(input logic [31:0] mask, input logic [3:0] typ);
        done_t e;
        e.mask = mask;
        e.typ  = typ;
        done_exp.push_back(e);
    endtask

    // Returns 1ns after the accepting edge.
    task automatic issue(input logic [63:0] word);
        int n = 0;
        while (!ins_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("issue_ready_wait", ins_ready, 1);
        ins = word;
        ins_valid = 1'b1;
        @(posedge clk); #1;
        ins_valid = 1'b0;
        ins = '1;
    endtask

    task automatic wait_hs();
        int n = 0;
        while (conf_valid != 4'b0000 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("hs_wait", conf_valid, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!ins_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_wait", ins_ready, 1);
    endtask

    task automatic run_std(input string name, input logic [63:0] word, input logic [3:0] lt,
                           input logic dp, input logic [3:0] tgt, input logic [15:0] num,
                           input logic [3:0] ch, input logic [3:0] row, input logic [3:0] pix,
                           input logic [31:0] mask);
        layer_type = lt;
        depool = dp;
        push_conf(tgt, num, ch, row, pix, lt, mask, dp);
        push_done(mask, tgt);
        issue(word);
        chk({name, "_cv"}, conf_valid, tgt);
        wait_hs();
        buf_done = tgt;
        @(posedge clk); #1;
        buf_done = 4'b0000;
        wait_idle();
    endtask

    task automatic run_err(input string name, input logic [63:0] word, input logic [3:0] lt);
        layer_type = lt;
        err_pending++;
        issue(word);
        chk({name, "_cv"}, conf_valid, 0);
        chk({name, "_busy"}, ins_ready, 0);
        @(posedge clk); #1;
        chk({name, "_ready_back"}, ins_ready, 1);
        chk({name, "_pulse_len"}, err_pulse, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int b = 3; b >= 0; b--) begin
                if (conf_valid[b] && conf_ready[b]) begin
                    if (conf_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL conf_unexpected actual=bit%0d required=none", b);
                    end else begin
                        conf_t e;
                        e = conf_exp.pop_front();
                        chk("hs_bit", 64'(b), 64'(e.b));
                        chk("hs_num", conf_num, e.num);
                        chk("hs_ch", conf_ch_num, e.ch);
                        chk("hs_row", conf_row_num, e.row);
                        chk("hs_pix", conf_pix_num, e.pix);
                        chk("hs_mode", conf_mode, e.mode);
                        chk("hs_mask", conf_mask, e.mask);
                        chk("hs_depool", conf_depool, e.dp);
                    end
                end
            end
            if (rx_done_pulse) begin
                if (done_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected actual=pulse required=none");
                end else begin
                    done_t d;
                    d = done_exp.pop_front();
                    chk("done_mask", buf_mask, d.mask);
                    chk("done_type", buf_type, d.typ);
                end
            end
            if (err_pulse) begin
                chk("err_expected", 64'(err_pending > 0), 1);
                if (err_pending > 0) err_pending--;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        layer_type = 4'h0; in_ch_seg = 4'h3; out_ch_seg = 4'h5; depool = 1'b0;
        ins_valid = 1'b0; ins = '0; conf_ready = 4'hF; buf_done = 4'h0;

        #2;
        chk("rst_ins_ready", ins_ready, 1);
        chk("rst_conf_valid", conf_valid, 0);
        chk("rst_conf_num", conf_num, 0);
        chk("rst_conf_mask", conf_mask, 0);
        chk("rst_buf_mask", buf_mask, 0);
        chk("rst_buf_type", buf_type, 0);
        chk("rst_ddr", {ddr1_ready_mux, ddr2_ready_mux}, 0);
        chk("rst_pulses", {rx_done_pulse, err_pulse}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // i+p, group mask, i owns num
        layer_type = 4'b0000;
        push_conf(4'b1010, 16'h0020, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0000_0F00, 1'b0);
        push_done(32'h0000_0F00, 4'b1010);
        issue(mk(OP_DW, 6'd2, 12'h034, 8'h20));
        chk("t1_cv", conf_valid, 4'b1010);
        chk("t1_mask", conf_mask, 32'h0000_0F00);
        chk("t1_num", conf_num, 16'h0020);
        chk("t1_ddr1", ddr1_ready_mux, 2'b01);
        chk("t1_ddr2", ddr2_ready_mux, 2'b01);
        chk("t1_busy", ins_ready, 0);
        @(posedge clk); #1;
        buf_done = 4'b1000;
        @(posedge clk); #1;
        chk("t1_no_early_done", rx_done_pulse, 0);
        buf_done = 4'b0010;
        @(posedge clk); #1;
        buf_done = 4'b0000;
        chk("t1_done", rx_done_pulse, 1);
        wait_idle();

        // d+p with p held off; d done coincident with its handshake must be ignored
        layer_type = 4'b0100;
        conf_ready = 4'b1101;
        push_conf(4'b0110, 16'h00A7, 4'h5, 4'hA, 4'h7, 4'h4, 32'hFFFF_FFFF, 1'b0);
        push_done(32'hFFFF_FFFF, 4'b0110);
        issue(mk(OP_G, 6'd0, 12'h0A7, 8'h11));
        chk("t2_cv", conf_valid, 4'b0110);
        buf_done = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            buf_done = 4'b0000;
            chk("t2_p_held", conf_valid, 4'b0010);
            chk("t2_num_stable", conf_num, 16'h00A7);
            chk("t2_ch_stable", conf_ch_num, 4'h5);
            chk("t2_row_stable", conf_row_num, 4'hA);
        end
        conf_ready = 4'hF;
        chk("t2_ddr1", ddr1_ready_mux, 2'b00);
        chk("t2_ddr2", ddr2_ready_mux, 2'b01);
        @(posedge clk); #1;
        chk("t2_cv_clear", conf_valid, 0);
        buf_done = 4'b1010;
        @(posedge clk); #1;
        buf_done = 4'b0000;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("t2_early_d_ignored", rx_done_pulse, 0);
        chk("t2_still_busy", ins_ready, 0);
        buf_done = 4'b0100;
        @(posedge clk); #1;
        buf_done = 4'b0000;
        chk("t2_done", rx_done_pulse, 1);
        wait_idle();

        run_std("t3_tail", mk(4'b1010, 6'd5, 12'h010, 8'h00), 4'b0101, 1'b1, 4'b0001,
                16'h0040, 4'h0, 4'h0, 4'h0, 32'h0000_0020);
        chk("t3_ddr1", ddr1_ready_mux, 2'b00);
        chk("t3_ddr2", ddr2_ready_mux, 2'b10);
        run_std("t3_a_plain", mk(4'b1000, 6'd1, 12'h123, 8'hFF), 4'b0100, 1'b0, 4'b0001,
                16'h0123, 4'h0, 4'h0, 4'h0, 32'h0000_00F0);
        run_std("t3_i_only", mk(OP_DW, 6'd7, 12'h000, 8'h9C), 4'b0100, 1'b0, 4'b1000,
                16'h009C, 4'h0, 4'h0, 4'h0, 32'hF000_0000);
        chk("t3_i_ddr", {ddr1_ready_mux, ddr2_ready_mux}, 4'b0110);
        run_std("t3_last_pe", mk(OP_DW, 6'd31, 12'h000, 8'h05), 4'b0001, 1'b0, 4'b1010,
                16'h0005, 4'h5, 4'h0, 4'h0, 32'h8000_0000);

        run_err("t4_grp_oob", mk(OP_DW, 6'd8, 12'h000, 8'h20), 4'b0000);
        run_err("t4_sel_oob", mk(OP_DW, 6'd32, 12'h000, 8'h20), 4'b0001);
        run_err("t4_bad_op", mk(4'b1000, 6'd0, 12'h000, 8'h00), 4'b0000);
        chk("t4_ddr_kept", {ddr1_ready_mux, ddr2_ready_mux}, 4'b0101);
        chk("t4_buf_mask_kept", buf_mask, 32'h8000_0000);

        // reset while waiting for d completion
        layer_type = 4'b0001;
        push_conf(4'b0100, 16'h0000, 4'h3, 4'h2, 4'h1, 4'h1, 32'hFFFF_FFFF, 1'b0);
        issue(mk(OP_D, 6'd0, 12'h321, 8'h00));
        wait_hs();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("t6_ins_ready", ins_ready, 1);
        chk("t6_conf_valid", conf_valid, 0);
        chk("t6_payload", {conf_num, conf_ch_num, conf_row_num, conf_pix_num, conf_mode}, 0);
        chk("t6_conf_mask", conf_mask, 0);
        chk("t6_buf", {buf_mask, buf_type}, 0);
        chk("t6_ddr", {ddr1_ready_mux, ddr2_ready_mux}, 0);
        chk("t6_pulses", {rx_done_pulse, err_pulse}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_std("t6_after", mk(OP_D, 6'd9, 12'h5C6, 8'h00), 4'b0001, 1'b0, 4'b0100,
                16'h0000, 4'h3, 4'hC, 4'h6, 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1;
        chk("left_conf", 64'(conf_exp.size()), 0);
        chk("left_done", 64'(done_exp.size()), 0);
        chk("left_err", 64'(err_pending), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_dispatch.md
Name: rx_dispatch

Overview:
- Parametrised receive-side instruction dispatcher between the instruction queue and the DDR→PE buffer loaders (i/d/p/a buffers).
- Decodes one read instruction at a time and issues a configuration handshake to each targeted buffer class; each valid is held until that buffer accepts.
- Tracks per-buffer completion and emits a single done pulse carrying the PE mask and buffer-type set.
- Generalises the PE count, the PE group size and the tail/data rate; adds held handshakes, completion tracking and illegal-instruction reporting.

Parameters:
- PE_NUM, 32, number of PEs (mask width)
- GRP_SIZE, 4, PEs per group when layer_type[0]=0; must be a power of 2 dividing PE_NUM
- INST_W, 64, instruction width
- TD_RATE, 4, tail-to-data word ratio for a-buffer tail transfers
- TIMEOUT_CYC, 65535, WAIT-state limit; used only with RX_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- layer_type  in  4  global layer mode
- in_ch_seg  in  4  input channel segments
- out_ch_seg  in  4  output channel segments
- depool  in  1  depool enable
- ins_valid  in  1  instruction valid
- ins_ready  out  1  instruction accept
- ins  in  INST_W  instruction: opcode[61:58], buf_id[57:52], p_size[51:40], row_num[47:44], pix_num[43:40], size[39:32]
- conf_valid  out  4  per-buffer config valid, bit order {i,d,p,a}
- conf_ready  in  4  per-buffer config ready, same bit order
- conf_mode  out  4  latched layer_type
- conf_num  out  16  transfer or index count
- conf_ch_num  out  4  channel count
- conf_row_num  out  4  row count
- conf_pix_num  out  4  pixel count
- conf_mask  out  PE_NUM  target PE mask
- conf_depool  out  1  latched depool
- buf_done  in  4  per-buffer transfer-complete pulse {i,d,p,a}
- rx_done_pulse  out  1  one-cycle instruction-complete pulse
- buf_mask  out  PE_NUM  mask of the completed instruction
- buf_type  out  4  buffer set of the completed instruction {i,d,p,a}
- err_pulse  out  1  one-cycle error pulse
- ddr1_ready_mux  out  2  DDR1 ready source select
- ddr2_ready_mux  out  2  DDR2 ready source select

Behaviour:
- Reset (async): FSM = IDLE; ins_ready=1; conf_valid=0; all payload outputs, buf_mask, buf_type and both mux selects = 0; rx_done_pulse=0; err_pulse=0.
- Decode opcodes per INS_CONST. "pe_mode" means layer_type[2:1]==2'b10.
- Targets:
  - RD_OP_DW → i, plus p when !pe_mode.
  - RD_OP_D → d.
  - RD_OP_G → d, plus p when pe_mode.
  - Any other opcode → a when pe_mode; otherwise illegal.
- Mask:
  - layer_type[0]=1 → 1<<buf_id.
  - layer_type[0]=0 → ((1<<GRP_SIZE)-1)<<(buf_id*GRP_SIZE).
  - d targets use all-ones.
  - Computed at PE_NUM width. Any set bit at or beyond PE_NUM makes the instruction illegal.
- Payload by target:
  - i: num = size.
  - d: ch_num = in_ch_seg; row_num and pix_num from instruction.
  - p: num = p_size zero-extended; ch_num = out_ch_seg for RD_OP_G, else size[3:0].
  - a: num = opcode[1] ? p_size*TD_RATE : p_size, truncated to 16 bits.
  - Payload is latched on accept and held stable while any conf_valid is high.
- FSM:
  - IDLE → ISSUE on ins_valid&ins_ready. conf_valid bits go high at T+1; ins_ready drops at T+1.
  - Illegal instruction: IDLE → ERR; err_pulse=1 for one cycle; then IDLE.
  - ISSUE: each conf_valid bit clears in the cycle after its conf_ready is seen. When all bits are clear → WAIT.
  - WAIT: sticky done flags per target. A buf_done counts only if it arrives strictly after that buffer's handshake cycle; earlier or same-cycle done is ignored. When all targeted flags are set → DONE.
  - DONE: rx_done_pulse=1 for one cycle; buf_mask and buf_type are valid from this cycle and hold until the next DONE. Then IDLE with ins_ready=1.
- Mux select update, at accept:
  - d only → ddr1=00, ddr2=00.
  - i+p → ddr1=01, ddr2=01.
  - i only → ddr1=01, ddr2=10.
  - p only → ddr1=10, ddr2 unchanged.
  - a only → ddr1 unchanged, ddr2=10.
  - d+p → ddr1=00, ddr2=01.
- buf_done on a non-targeted bit is ignored in every state.
- ins is ignored whenever ins_ready=0.

Optional Feature:
- Macro RX_TIMEOUT_EN.
- With it: a 16-bit counter runs in WAIT and resets on state entry. On reaching TIMEOUT_CYC: err_pulse=1 for one cycle, no rx_done_pulse, FSM → IDLE, done flags cleared.
- Without it: WAIT persists until all targeted done flags are set; err_pulse is raised only for illegal instructions.

Test Plan:
- RD_OP_DW, layer_type=4'b0000, buf_id=2, size=8'h20; conf_ready=1 → at T+1 conf_valid=4'b1010, conf_mask=32'h0000_0F00, conf_num=16'h0020; buf_done i then p → rx_done_pulse, buf_type=4'b1010.
- RD_OP_G, layer_type=4'b0100, out_ch_seg=5; conf_ready[1] low for 3 cycles → conf_valid[1] held 3 extra cycles while payload stays stable; ddr2_ready_mux=01.
- Tail opcode with opcode[1]=1, pe_mode, p_size=12'h010, TD_RATE=4 → conf_valid=4'b0001, conf_num=16'h0040.
- layer_type[0]=0, buf_id=8, PE_NUM=32 → err_pulse one cycle, no conf_valid, ins_ready back to 1 two cycles later.
- buf_done[2] asserted in the same cycle as the d handshake → ignored; a later buf_done[2] → rx_done_pulse.
- rst asserted mid-WAIT → all outputs return to reset values immediately; next instruction is accepted normally.
